shift_sequencer: RTL

Parametrised multi-mode shift register with a built-in shift-count sequencer. It is the successor to the single-direction serial right shifter. It supports logical, arithmetic and rotate shifts in both directions. A single start command shifts by a requested amount, one bit per clock, and reports completion with a busy/done handshake. It sits in the datapath wherever a controller needs a variable-distance shift, such as multiplier/divider normalisation, without sequencing each bit itself.

---
 rtl/shift_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-mode shift register that shifts by a requested amount, one bit per clock.
// Latency: amount+1 edges from start to done; load/start/mode/amount are ignored while busy.
module shift_sequencer #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIZE-1:0]  data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  output logic [SIZE-1:0]  data_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [SIZE-1:0]  data_n, shifted;
  logic             carry_n, shift_carry, done_n;
  logic [CNT_W-1:0] cnt, cnt_n, eff_amt;
  logic [2:0]       mode_q, mode_n;

  assign eff_amt = (amount > CNT_W'(SIZE)) ? CNT_W'(SIZE) : amount;
  assign busy    = (state == SHIFT);

  // One-bit shift of the current register under the latched mode
  always_comb begin
    shifted     = data_out;
    shift_carry = carry_out;
    case (mode_q)
      3'b000: begin
        shifted     = {serial_in, data_out[SIZE-1:1]};
        shift_carry = data_out[0];
      end
      3'b001: begin
        shifted     = {data_out[SIZE-2:0], serial_in};
        shift_carry = data_out[SIZE-1];
      end
      3'b010: begin
        shifted     = {data_out[SIZE-1], data_out[SIZE-1:1]};
        shift_carry = data_out[0];
      end
      3'b011: begin
        shifted     = {data_out[0], data_out[SIZE-1:1]};
        shift_carry = data_out[0];
      end
      3'b100: begin
        shifted     = {data_out[SIZE-2:0], data_out[SIZE-1]};
        shift_carry = data_out[SIZE-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    data_n  = data_out;
    carry_n = carry_out;
    cnt_n   = cnt;
    mode_n  = mode_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          data_n  = data_in;
          carry_n = 1'b0;
        end else if (start) begin
          mode_n = mode;
          // Reserved modes complete as a zero-distance operation
          if (eff_amt == '0 || mode > 3'b100) begin
            done_n = 1'b1;
          end else begin
            state_n = SHIFT;
            cnt_n   = eff_amt;
          end
        end
      end
      SHIFT: begin
        data_n  = shifted;
        carry_n = shift_carry;
        cnt_n   = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_out  <= '0;
      carry_out <= 1'b0;
      cnt       <= '0;
      mode_q    <= 3'b000;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      data_out  <= data_n;
      carry_out <= carry_n;
      cnt       <= cnt_n;
      mode_q    <= mode_n;
      done      <= done_n;
    end
  end

endmodule
